// File: rtl/alu_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_step_sequencer
//  Description : Control-step sequencer for a single-bus datapath. It walks
//                fetch (T0..T2, with T1W memory wait), decodes the latched
//                opcode, then runs the register-to-register ALU steps
//                (T3..T5, and T6 for wide MUL/DIV results). All control
//                outputs are registered and decoded from the next state, so
//                each output is high for exactly the cycle of its state.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    Clock        in   system clock
//    Clear_n      in   asynchronous active-low reset
//    Run          in   start request, only looked at in IDLE
//    Mem_ready    in   memory read data valid (sampled in T1/T1W)
//    IR           in   instruction register contents [DATA_W]
//    PCout..HIin  out  one-bit datapath control strobes
//    Busy         out  high in every state except IDLE
//    Done         out  one-cycle pulse in the IDLE cycle after completion
//    Illegal      out  one-cycle pulse for an undefined opcode
//    Rout, Rin    out  one-hot register drive / load selects [REG_N]
//    alu_op       out  opcode presented to the ALU (T4 only, else 0)
//  Configuration
//    ALU_STEP_MULDIV_EN  when defined, MUL (0x0F) and DIV (0x10) are legal
//                        and use T5 (LO load) plus T6 (HI load).
// ============================================================================
module alu_step_sequencer #(
   parameter int DATA_W = 32,
   parameter int OPC_W  = 5,
   parameter int REG_N  = 16
) (
   input  logic              Clock,
   input  logic              Clear_n,
   input  logic              Run,
   input  logic              Mem_ready,
   input  logic [DATA_W-1:0] IR,
   output logic              PCout,
   output logic              MARin,
   output logic              IncPC,
   output logic              Zin,
   output logic              Zlowout,
   output logic              Zhighout,
   output logic              PCin,
   output logic              Read,
   output logic              MDRin,
   output logic              MDRout,
   output logic              IRin,
   output logic              Yin,
   output logic              LOin,
   output logic              HIin,
   output logic              Busy,
   output logic              Done,
   output logic              Illegal,
   output logic [REG_N-1:0]  Rout,
   output logic [REG_N-1:0]  Rin,
   output logic [OPC_W-1:0]  alu_op
);

   localparam int RSEL_W = (REG_N > 1) ? $clog2(REG_N) : 1;
   localparam int RA_MSB = DATA_W - 1 - OPC_W;
   localparam int RB_MSB = RA_MSB - RSEL_W;
   localparam int RC_MSB = RB_MSB - RSEL_W;

   localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(8'h03);
   localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(8'h04);
   localparam logic [OPC_W-1:0] OP_AND = OPC_W'(8'h05);
   localparam logic [OPC_W-1:0] OP_OR  = OPC_W'(8'h06);
   localparam logic [OPC_W-1:0] OP_SHR = OPC_W'(8'h07);
   localparam logic [OPC_W-1:0] OP_SHL = OPC_W'(8'h08);
   localparam logic [OPC_W-1:0] OP_ROR = OPC_W'(8'h09);
   localparam logic [OPC_W-1:0] OP_ROL = OPC_W'(8'h0A);
`ifdef ALU_STEP_MULDIV_EN
   localparam logic [OPC_W-1:0] OP_MUL = OPC_W'(8'h0F);
   localparam logic [OPC_W-1:0] OP_DIV = OPC_W'(8'h10);
`endif

   typedef enum logic [3:0] {
      IDLE = 4'd0,
      T0   = 4'd1,
      T1   = 4'd2,
      T1W  = 4'd3,
      T2   = 4'd4,
      T3   = 4'd5,
      T4   = 4'd6,
      T5   = 4'd7,
      T6   = 4'd8,
      ILL  = 4'd9
   } state_t;

   typedef struct packed {
      logic pc_out;
      logic mar_in;
      logic inc_pc;
      logic z_in;
      logic z_lowout;
`ifdef ALU_STEP_MULDIV_EN
      logic z_highout;
      logic lo_in;
      logic hi_in;
`endif
      logic pc_in;
      logic read;
      logic mdr_in;
      logic mdr_out;
      logic ir_in;
      logic y_in;
      logic busy;
      logic done;
      logic illegal;
   } ctl_t;

   // Instruction fields taken straight from IR; only consumed while in T2.
   logic [OPC_W-1:0]  w_ir_opc;
   logic [RSEL_W-1:0] w_ir_ra;
   logic [RSEL_W-1:0] w_ir_rb;
   logic [RSEL_W-1:0] w_ir_rc;
   logic              unused_ir;

   assign w_ir_opc  = IR[DATA_W-1 -: OPC_W];
   assign w_ir_ra   = IR[RA_MSB -: RSEL_W];
   assign w_ir_rb   = IR[RB_MSB -: RSEL_W];
   assign w_ir_rc   = IR[RC_MSB -: RSEL_W];
   assign unused_ir = ^IR;

   state_t            state_q, state_d;
   logic              armed_q;
   logic [OPC_W-1:0]  opc_q, opc_d;
   logic [RSEL_W-1:0] ra_q, ra_d;
   logic [RSEL_W-1:0] rb_q, rb_d;
   logic [RSEL_W-1:0] rc_q, rc_d;
`ifdef ALU_STEP_MULDIV_EN
   logic              muldiv_q, muldiv_d;
`endif
   ctl_t              ctl_q, ctl_d;
   logic [REG_N-1:0]  rout_q, rout_d;
   logic [REG_N-1:0]  rin_q, rin_d;
   logic [OPC_W-1:0]  alu_op_q, alu_op_d;

   function automatic logic [REG_N-1:0] dec_onehot(input logic [RSEL_W-1:0] sel);
      logic [REG_N-1:0] v;
      v = '0;
      for (int i = 0; i < REG_N; i++) begin
         if (sel == RSEL_W'(i)) v[i] = 1'b1;
      end
      return v;
   endfunction

   function automatic logic opc_legal(input logic [OPC_W-1:0] op);
      logic ok;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_SHR, OP_SHL, OP_ROR, OP_ROL: ok = 1'b1;
`ifdef ALU_STEP_MULDIV_EN
         OP_MUL, OP_DIV:                 ok = 1'b1;
`endif
         default:                        ok = 1'b0;
      endcase
      return ok;
   endfunction

   // armed_q holds IDLE for one edge after reset release so the first edge
   // following an asynchronous deassertion never launches an instruction.
   always_ff @(posedge Clock or negedge Clear_n) begin
      if (!Clear_n) begin
         state_q  <= IDLE;
         armed_q  <= 1'b0;
         opc_q    <= '0;
         ra_q     <= '0;
         rb_q     <= '0;
         rc_q     <= '0;
`ifdef ALU_STEP_MULDIV_EN
         muldiv_q <= 1'b0;
`endif
         ctl_q    <= '0;
         rout_q   <= '0;
         rin_q    <= '0;
         alu_op_q <= '0;
      end else begin
         state_q  <= state_d;
         armed_q  <= 1'b1;
         opc_q    <= opc_d;
         ra_q     <= ra_d;
         rb_q     <= rb_d;
         rc_q     <= rc_d;
`ifdef ALU_STEP_MULDIV_EN
         muldiv_q <= muldiv_d;
`endif
         ctl_q    <= ctl_d;
         rout_q   <= rout_d;
         rin_q    <= rin_d;
         alu_op_q <= alu_op_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      opc_d    = opc_q;
      ra_d     = ra_q;
      rb_d     = rb_q;
      rc_d     = rc_q;
`ifdef ALU_STEP_MULDIV_EN
      muldiv_d = muldiv_q;
`endif
      ctl_d    = '0;
      rout_d   = '0;
      rin_d    = '0;
      alu_op_d = '0;

      // ---------------- next state ----------------
      case (state_q)
         IDLE: if (Run && armed_q) state_d = T0;
         T0:   state_d = T1;
         T1:   state_d = Mem_ready ? T2 : T1W;
         T1W:  if (Mem_ready) state_d = T2;
         T2: begin
            // Fields are captured here so later steps ignore IR changes.
            opc_d    = w_ir_opc;
            ra_d     = w_ir_ra;
            rb_d     = w_ir_rb;
            rc_d     = w_ir_rc;
`ifdef ALU_STEP_MULDIV_EN
            muldiv_d = (w_ir_opc == OP_MUL) || (w_ir_opc == OP_DIV);
`endif
            state_d  = opc_legal(w_ir_opc) ? T3 : ILL;
         end
         T3:   state_d = T4;
         T4:   state_d = T5;
`ifdef ALU_STEP_MULDIV_EN
         T5:   state_d = muldiv_q ? T6 : IDLE;
`else
         T5:   state_d = IDLE;
`endif
         T6:   state_d = IDLE;
         ILL:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // ---------------- outputs of the state being entered ----------------
      ctl_d.busy = (state_d != IDLE);
      case (state_d)
         T0: begin
            ctl_d.pc_out = 1'b1;
            ctl_d.mar_in = 1'b1;
            ctl_d.inc_pc = 1'b1;
            ctl_d.z_in   = 1'b1;
         end
         T1: begin
            ctl_d.z_lowout = 1'b1;
            ctl_d.pc_in    = 1'b1;
            ctl_d.read     = 1'b1;
            ctl_d.mdr_in   = 1'b1;
         end
         T1W: begin
            // PC was already loaded in T1; only the memory read is held.
            ctl_d.read   = 1'b1;
            ctl_d.mdr_in = 1'b1;
         end
         T2: begin
            ctl_d.mdr_out = 1'b1;
            ctl_d.ir_in   = 1'b1;
         end
         T3: begin
            rout_d     = dec_onehot(rb_d);
            ctl_d.y_in = 1'b1;
         end
         T4: begin
            rout_d     = dec_onehot(rc_d);
            ctl_d.z_in = 1'b1;
            alu_op_d   = opc_d;
         end
         T5: begin
            ctl_d.z_lowout = 1'b1;
`ifdef ALU_STEP_MULDIV_EN
            if (muldiv_d) ctl_d.lo_in = 1'b1;
            else          rin_d       = dec_onehot(ra_d);
`else
            rin_d = dec_onehot(ra_d);
`endif
         end
         T6: begin
`ifdef ALU_STEP_MULDIV_EN
            ctl_d.z_highout = 1'b1;
            ctl_d.hi_in     = 1'b1;
`endif
         end
         ILL: ctl_d.illegal = 1'b1;
         default: ;
      endcase

      // Done marks the IDLE cycle reached from a completed instruction only;
      // the ILL path returns to IDLE without it.
      ctl_d.done = (state_d == IDLE) && ((state_q == T5) || (state_q == T6));
   end

   assign PCout    = ctl_q.pc_out;
   assign MARin    = ctl_q.mar_in;
   assign IncPC    = ctl_q.inc_pc;
   assign Zin      = ctl_q.z_in;
   assign Zlowout  = ctl_q.z_lowout;
   assign PCin     = ctl_q.pc_in;
   assign Read     = ctl_q.read;
   assign MDRin    = ctl_q.mdr_in;
   assign MDRout   = ctl_q.mdr_out;
   assign IRin     = ctl_q.ir_in;
   assign Yin      = ctl_q.y_in;
   assign Busy     = ctl_q.busy;
   assign Done     = ctl_q.done;
   assign Illegal  = ctl_q.illegal;
`ifdef ALU_STEP_MULDIV_EN
   assign Zhighout = ctl_q.z_highout;
   assign LOin     = ctl_q.lo_in;
   assign HIin     = ctl_q.hi_in;
`else
   assign Zhighout = 1'b0;
   assign LOin     = 1'b0;
   assign HIin     = 1'b0;
`endif
   assign Rout     = rout_q;
   assign Rin      = rin_q;
   assign alu_op   = alu_op_q;

endmodule
`default_nettype wire
